pse_rank_sched: RTL and testbench
=================================

# pse_rank_sched

Sequencing controller for the polygon-sort engine's shared cross-product unit. After the vector-generation step has produced up to `MAX_N` anchor-relative vectors, this block issues every ordered (candidate, other) index pair to the single cross-product unit, one pair per cycle, fully pipelined. It counts the sign results and writes one angular rank per candidate into the sort engine's answer-index table. It replaces ad-hoc counter juggling inside the engine with one scheduler that owns the cross-unit operand selects.

## Interface

Parameters:
- `MAX_N`, default 5: maximum number of vectors (points minus anchor).
- `CROSS_LAT`, default 1: cycles from `issue` to a valid `cross_pos`; legal values 0..3.

Ports:
- `clk` input, 1 bit: clock, rising edge.
- `reset` input, 1 bit: asynchronous, active-high.
- `start` input, 1 bit: one-cycle request to begin a ranking pass.
- `vec_num` input, 3 bits: number of valid vectors; sampled only on an accepted `start`.
- `busy` output, 1 bit: a pass is in progress.
- `issue` output, 1 bit: the operand selects are valid this cycle.
- `sel_a` output, 3 bits: candidate vector index, first cross operand.
- `sel_b` output, 3 bits: other vector index, second cross operand.
- `cross_pos` input, 1 bit: 1 when (x_a·y_b − x_b·y_a) > 0; valid exactly `CROSS_LAT` cycles after the matching `issue`.
- `rank_we` output, 1 bit: rank write strobe.
- `rank_idx` output, 3 bits: candidate index being written.
- `rank_val` output, 3 bits: rank of that candidate, in the range 0..N−1.
- `done` output, 1 bit: one-cycle pulse marking the end of the pass.

## Operation

- **States:** IDLE, ISSUE, DRAIN, FIN.
- **Accepting a pass:** `start` is accepted only in IDLE. On acceptance the block latches N = min(`vec_num`, `MAX_N`).
  - If N ≥ 2, the next state is ISSUE.
  - If N < 2, the next state is FIN. No issues and no rank writes occur.
- **ISSUE:**
  - `issue`=1 every cycle.
  - The candidate c counts 0..N−1 (outer loop). The other o counts 0..N−1 (inner loop), skipping o==c.
  - Outputs are `sel_a`=c, `sel_b`=o.
  - Total issues per pass: N·(N−1). After the last issue the block moves to DRAIN, or directly to FIN when `CROSS_LAT`=0.
- **Tag pipeline:** each issue pushes a tag {c, last_of_candidate} into a `CROSS_LAT`-deep shift register, aligned with `cross_pos`.
- **Accumulation:** when a tag emerges, the accumulator adds (`cross_pos`==0). When the tag is last_of_candidate:
  - `rank_we`=1, `rank_idx`=c, `rank_val`=acc + (`cross_pos`==0).
  - The accumulator is cleared in the same cycle.
- **DRAIN:** waits until the final tag retires, then moves to FIN.
- **FIN:** `done`=1 for one cycle, then IDLE.
- **Output defaults:** `sel_a`/`sel_b` are 0 whenever `issue`=0. `rank_idx`/`rank_val` are 0 whenever `rank_we`=0.
- **Arithmetic:** the accumulator is 3 bits and cannot overflow, since its maximum is MAX_N−1 = 4. Index counters are 3 bits and wrap only under block control.

## Timing

- **Reset values:** all outputs are 0 (`busy`, `issue`, `sel_a`, `sel_b`, `rank_we`, `rank_idx`, `rank_val`, `done`). State is IDLE, and the tag pipeline and accumulator are cleared.
- **Cycle numbering:** `start` is sampled at cycle 0.
  - First issue is at cycle 1; last issue is at cycle N(N−1).
  - The final `rank_we` is at cycle N(N−1)+`CROSS_LAT`.
  - `done` is asserted in the cycle after the final `rank_we`: cycle N(N−1)+`CROSS_LAT`+1.
  - When N < 2, `done` is at cycle 1.
- **`busy`:** 1 from cycle 1 through the `done` cycle inclusive.
- **Back-to-back passes:** a new `start` is accepted in the first cycle after `done`, when the block is back in IDLE.
- **`start` while busy:** ignored. Neither `vec_num` nor the in-flight pass is affected.
- **`vec_num` changes mid-pass:** ignored, because N is latched at `start`.
- **`cross_pos` outside a tag slot:** ignored.
- **Reset mid-pass:** asynchronous return to IDLE. Outputs go to 0 immediately, the pipeline is flushed, and no further `rank_we` or `done` occurs.

## Test plan

- **Minimal pass:** `CROSS_LAT`=1, N=2. Bench returns `cross_pos`=1 for (0,1) and 0 for (1,0).
  - Issues: cycle 1 (0,1), cycle 2 (1,0).
  - `rank_we` at cycle 2 (idx 0, val 0) and cycle 3 (idx 1, val 1).
  - `done` at cycle 4.
- **Full pass:** N=5, `CROSS_LAT`=2. Bench returns `cross_pos`=(`sel_a`<`sel_b`).
  - Exactly 20 issues in cycles 1..20.
  - Ranks 0,1,2,3,4 for idx 0..4; last `rank_we` at cycle 22, `done` at cycle 23.
- **Zero latency:** `CROSS_LAT`=0, N=3, same bench model.
  - Ranks 0,1,2.
  - Final write at cycle 6, `done` at cycle 7, with no DRAIN cycle.
- **Edge sizes:**
  - `vec_num`=1: `done` at cycle 1, with zero `issue` and zero `rank_we`.
  - `vec_num`=7: clamped to N=5, so 20 issues.
- **Protocol robustness:**
  - `start` pulsed at cycle 5 of an N=4 pass: ignored, and the pass completes unchanged.
  - A second `start` in the cycle after `done` begins a new pass.
- **Reset mid-pass:** `reset` asserted at cycle 8 of an N=5 pass.
  - All outputs are 0 immediately.
  - No `done`, and no `rank_we` after reset even though `cross_pos` keeps toggling.
  - A subsequent pass produces correct ranks.

Source files
------------

// File: rtl/pse_rank_sched.sv
// Angular-rank scheduler for the polygon-sort engine's shared cross unit.
// Issues every ordered (candidate, other) pair and turns sign counts into ranks.
module pse_rank_sched #(
   parameter int MAX_N     = 5,
   parameter int CROSS_LAT = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [2:0] vec_num,
   output logic       busy,
   output logic       issue,
   output logic [2:0] sel_a,
   output logic [2:0] sel_b,
   input  logic       cross_pos,
   output logic       rank_we,
   output logic [2:0] rank_idx,
   output logic [2:0] rank_val,
   output logic       done
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_DRAIN,
      S_FIN
   } state_t;

   localparam logic [2:0] MAXN3 = 3'(MAX_N);

   state_t     state_q, state_d;
   logic [2:0] n_q, n_d;
   logic [2:0] c_q, c_d;
   logic [2:0] o_q, o_d;
   logic [2:0] acc_q, acc_d;

   logic       is_issue;
   logic [2:0] nm1;
   logic [2:0] n_clamp;
   logic       last_o;
   logic       last_pair;
   logic       tv;
   logic       tl;
   logic [2:0] tc;
   logic       older_v;
   logic [2:0] inc;

   assign is_issue  = (state_q == S_ISSUE);
   assign nm1       = n_q - 3'd1;
   assign n_clamp   = (vec_num > MAXN3) ? MAXN3 : vec_num;
   // The last candidate never pairs with itself, so its final other is N-2.
   assign last_o    = (o_q == nm1) ||
                      ((o_q == nm1 - 3'd1) && (c_q == nm1));
   assign last_pair = last_o && (c_q == nm1);

   if (CROSS_LAT == 0) begin : g_direct
      assign tv      = is_issue;
      assign tl      = last_o;
      assign tc      = c_q;
      assign older_v = 1'b0;
   end else begin : g_pipe
      logic [CROSS_LAT-1:0] pv_q;
      logic [CROSS_LAT-1:0] pl_q;
      logic [2:0]           pc_q [CROSS_LAT];

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            pv_q <= '0;
            pl_q <= '0;
            for (int k = 0; k < CROSS_LAT; k++) begin
               pc_q[k] <= '0;
            end
         end else begin
            pv_q[0] <= is_issue;
            pl_q[0] <= last_o;
            pc_q[0] <= c_q;
            for (int k = 1; k < CROSS_LAT; k++) begin
               pv_q[k] <= pv_q[k-1];
               pl_q[k] <= pl_q[k-1];
               pc_q[k] <= pc_q[k-1];
            end
         end
      end

      assign tv = pv_q[CROSS_LAT-1];
      assign tl = pl_q[CROSS_LAT-1];
      assign tc = pc_q[CROSS_LAT-1];

      always_comb begin
         older_v = 1'b0;
         for (int k = 0; k < CROSS_LAT - 1; k++) begin
            older_v = older_v | pv_q[k];
         end
      end
   end

   assign inc = {2'b00, ~cross_pos};

   always_comb begin
      acc_d = acc_q;
      if (tv) begin
         acc_d = tl ? 3'd0 : acc_q + inc;
      end
   end

   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      c_d     = c_q;
      o_d     = o_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               n_d     = n_clamp;
               c_d     = 3'd0;
               o_d     = 3'd1;
               state_d = (n_clamp >= 3'd2) ? S_ISSUE : S_FIN;
            end
         end
         S_ISSUE: begin
            if (last_o) begin
               c_d = c_q + 3'd1;
               o_d = 3'd0;
            end else if (o_q + 3'd1 == c_q) begin
               o_d = o_q + 3'd2;
            end else begin
               o_d = o_q + 3'd1;
            end
            if (last_pair) begin
               state_d = (CROSS_LAT == 0) ? S_FIN : S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (tv && !older_v) begin
               state_d = S_FIN;
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         n_q     <= '0;
         c_q     <= '0;
         o_q     <= '0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         c_q     <= c_d;
         o_q     <= o_d;
         acc_q   <= acc_d;
      end
   end

   assign busy     = (state_q != S_IDLE);
   assign done     = (state_q == S_FIN);
   assign issue    = is_issue;
   assign sel_a    = is_issue ? c_q : 3'd0;
   assign sel_b    = is_issue ? o_q : 3'd0;
   assign rank_we  = tv && tl;
   assign rank_idx = rank_we ? tc : 3'd0;
   assign rank_val = rank_we ? acc_q + inc : 3'd0;

endmodule

// File: tb/tb_pse_rank_sched.sv
// Bench for pse_rank_sched: three instances at CROSS_LAT 0,1,2 driven
// pass by pass against a pair-list / rank-count reference model.
module tb_pse_rank_sched;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] start_v = '0;
   logic [8:0] vn_v = '0;
   logic [2:0] cpos_v = '0;
   wire  [2:0] busy_v, issue_v, we_v, done_v;
   wire  [8:0] sela_v, selb_v, ridx_v, rval_v;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      pse_rank_sched #(.MAX_N(5), .CROSS_LAT(g)) u_dut (
         .clk      (clk),
         .reset    (reset),
         .start    (start_v[g]),
         .vec_num  (vn_v[3*g +: 3]),
         .busy     (busy_v[g]),
         .issue    (issue_v[g]),
         .sel_a    (sela_v[3*g +: 3]),
         .sel_b    (selb_v[3*g +: 3]),
         .cross_pos(cpos_v[g]),
         .rank_we  (we_v[g]),
         .rank_idx (ridx_v[3*g +: 3]),
         .rank_val (rval_v[3*g +: 3]),
         .done     (done_v[g])
      );
   end

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp_v);
      end
   endtask

   task automatic chk_all(input int k, input string tg,
                          input logic b, input logic is,
                          input logic [2:0] a, input logic [2:0] o,
                          input logic we, input logic [2:0] ri,
                          input logic [2:0] rv, input logic dn);
      chk({tg, " busy"},     {7'd0, busy_v[k]},         {7'd0, b});
      chk({tg, " issue"},    {7'd0, issue_v[k]},        {7'd0, is});
      chk({tg, " sel_a"},    {5'd0, sela_v[3*k +: 3]},  {5'd0, a});
      chk({tg, " sel_b"},    {5'd0, selb_v[3*k +: 3]},  {5'd0, o});
      chk({tg, " rank_we"},  {7'd0, we_v[k]},           {7'd0, we});
      chk({tg, " rank_idx"}, {5'd0, ridx_v[3*k +: 3]},  {5'd0, ri});
      chk({tg, " rank_val"}, {5'd0, rval_v[3*k +: 3]},  {5'd0, rv});
      chk({tg, " done"},     {7'd0, done_v[k]},         {7'd0, dn});
   endtask

   // mode 0: cross_pos = (a < b); mode 1: random sign per pair.
   task automatic run_pass(input int k, input int vn, input int mode,
                           input int rst_at, input int ign_at);
      int n, p, t_end, j;
      int pc[32], po[32], pl[32], pb[32];
      int rank[8];
      logic b, is, we, dn;
      logic [2:0] a, o, ri, rv;
      string tg;
      n = (vn > 5) ? 5 : vn;
      p = 0;
      for (int c = 0; c < 8; c++) rank[c] = 0;
      for (int c = 0; c < n; c++) begin
         for (int x = 0; x < n; x++) begin
            if (x != c) begin
               pc[p] = c;
               po[p] = x;
               pl[p] = 0;
               pb[p] = (mode == 0) ? int'(c < x) : int'($urandom_range(0, 1));
               if (pb[p] == 0) rank[c]++;
               p++;
            end
         end
         if (p > 0 && pc[p-1] == c) pl[p-1] = 1;
      end
      if (rst_at > 0) t_end = p + k + 3;
      else if (n < 2) t_end = 1;
      else t_end = p + k + 1;

      @(negedge clk);
      start_v[k] = 1'b1;
      vn_v[3*k +: 3] = 3'(vn);
      cpos_v[k] = 1'($urandom_range(0, 1));
      #1;
      tg = $sformatf("L%0d N%0d t0", k, vn);
      chk({tg, " busy"},  {7'd0, busy_v[k]}, 8'd0);
      chk({tg, " done"},  {7'd0, done_v[k]}, 8'd0);
      @(posedge clk);
      for (int t = 1; t <= t_end; t++) begin
         @(negedge clk);
         start_v[k] = (t == ign_at) ? 1'b1 : 1'b0;
         vn_v[3*k +: 3] = 3'($urandom_range(0, 7));
         if (rst_at > 0 && t == rst_at) reset = 1'b1;
         if (rst_at > 0 && t == rst_at + 1) reset = 1'b0;
         j = t - k;
         if (j >= 1 && j <= p) cpos_v[k] = pb[j-1][0];
         else cpos_v[k] = 1'($urandom_range(0, 1));
         #1;
         if (n < 2) begin
            b = (t == 1);
            dn = (t == 1);
         end else begin
            b = (t <= p + k + 1);
            dn = (t == p + k + 1);
         end
         is = (t >= 1 && t <= p);
         a = is ? 3'(pc[t-1]) : 3'd0;
         o = is ? 3'(po[t-1]) : 3'd0;
         we = (j >= 1 && j <= p) ? (pl[j-1] != 0) : 1'b0;
         ri = we ? 3'(pc[j-1]) : 3'd0;
         rv = we ? 3'(rank[pc[j-1]]) : 3'd0;
         if (rst_at > 0 && t >= rst_at) begin
            b = 0; is = 0; a = 0; o = 0; we = 0; ri = 0; rv = 0; dn = 0;
         end
         tg = $sformatf("L%0d N%0d t%0d", k, vn, t);
         chk_all(k, tg, b, is, a, o, we, ri, rv, dn);
      end
      start_v[k] = 1'b0;
   endtask

   initial begin
      #1;
      for (int k = 0; k < 3; k++) begin
         chk_all(k, $sformatf("reset L%0d", k), 0, 0, 0, 0, 0, 0, 0, 0);
      end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      run_pass(1, 2, 0, 0, 0);
      run_pass(2, 5, 0, 0, 0);
      run_pass(0, 3, 0, 0, 0);
      run_pass(1, 1, 0, 0, 0);
      run_pass(2, 0, 1, 0, 0);
      run_pass(1, 7, 1, 0, 0);
      run_pass(2, 4, 1, 0, 5);
      run_pass(2, 3, 1, 0, 0);
      run_pass(0, 5, 1, 0, 0);
      run_pass(1, 5, 0, 8, 0);
      run_pass(1, 5, 1, 0, 0);
      run_pass(2, 5, 1, 4, 0);
      run_pass(2, 2, 1, 0, 0);
      for (int i = 0; i < 8; i++) begin
         run_pass(int'($urandom_range(0, 2)), int'($urandom_range(0, 7)),
                  1, 0, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
